// File: rtl/spm_pkg.sv
// spm_pkg: datapath width, sequencer state type and the spm latency shared by
// spm_seq and the spm it drives.
package spm_pkg;

    localparam int DATA_W          = 32;
    localparam int SPM_LAT_DEFAULT = 2;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } seq_state_e;

    typedef struct packed {
        logic [DATA_W-1:0] a0;
        logic [DATA_W-1:0] b0;
        logic [DATA_W-1:0] a1;
        logic [DATA_W-1:0] b1;
    } spm_beat_t;

endpackage

// File: rtl/spm_seq_if.sv
// spm_seq_if: job request, operand stream, spm side-channel and result handshake.
// The slave modport is the sequencer's view; master is the surrounding logic.
interface spm_seq_if #(
    parameter int LEN_W = 8
);

    logic                       start;
    logic [LEN_W-1:0]           len;
    logic                       busy;

    logic                       in_valid;
    logic                       in_ready;
    logic [spm_pkg::DATA_W-1:0] a0;
    logic [spm_pkg::DATA_W-1:0] b0;
    logic [spm_pkg::DATA_W-1:0] a1;
    logic [spm_pkg::DATA_W-1:0] b1;

    logic [spm_pkg::DATA_W-1:0] spm_a0;
    logic [spm_pkg::DATA_W-1:0] spm_b0;
    logic [spm_pkg::DATA_W-1:0] spm_a1;
    logic [spm_pkg::DATA_W-1:0] spm_b1;
    logic [spm_pkg::DATA_W-1:0] spm_q;

    logic                       res_valid;
    logic                       res_ready;
    logic [spm_pkg::DATA_W-1:0] res_data;

    modport slave (
        input  start, len, in_valid, a0, b0, a1, b1, spm_q, res_ready,
        output busy, in_ready, spm_a0, spm_b0, spm_a1, spm_b1, res_valid, res_data
    );

    modport master (
        output start, len, in_valid, a0, b0, a1, b1, spm_q, res_ready,
        input  busy, in_ready, spm_a0, spm_b0, spm_a1, spm_b1, res_valid, res_data
    );

endinterface

// File: rtl/spm_tag_pipe.sv
// spm_tag_pipe: one bit per cycle marking which spm results belong to real beats,
// aligned so the oldest tag lines up with the matching spm_q.
module spm_tag_pipe #(
    parameter int DEPTH = 3
) (
    input  logic clk,
    input  logic areset,
    input  logic push,
    output logic oldest,
    output logic empty_next
);

    logic [DEPTH-1:0] tags_q;
    logic [DEPTH-1:0] tags_d;

    always_comb begin
        tags_d = {tags_q[DEPTH-2:0], push};
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            tags_q <= '0;
        end else begin
            tags_q <= tags_d;
        end
    end

    assign oldest     = tags_q[DEPTH-1];
    assign empty_next = (tags_d == '0);

endmodule

// File: rtl/spm_seq.sv
// spm_seq: dot-product sequencer that streams operand beats into an external spm
// and accumulates its partial sums into a single 32-bit result.
module spm_seq
    import spm_pkg::*;
#(
    parameter int SPM_LAT = SPM_LAT_DEFAULT,
    parameter int LEN_W   = 8
) (
    input  logic     clk,
    input  logic     areset,
    spm_seq_if.slave bus
);

    seq_state_e        state_q;
    seq_state_e        state_d;
    logic [LEN_W-1:0]  beats_left_q;
    logic [LEN_W-1:0]  beats_left_d;
    logic [DATA_W-1:0] acc_q;
    logic [DATA_W-1:0] acc_d;
    spm_beat_t         spm_ops_q;
    spm_beat_t         spm_ops_d;

    logic in_ready;
    logic accept;
    logic tag_oldest;
    logic pipe_empty_next;

    spm_tag_pipe #(
        .DEPTH (SPM_LAT + 1)
    ) u_tag_pipe (
        .clk        (clk),
        .areset     (areset),
        .push       (accept),
        .oldest     (tag_oldest),
        .empty_next (pipe_empty_next)
    );

    always_comb begin
        state_d      = state_q;
        beats_left_d = beats_left_q;
        acc_d        = acc_q;

        in_ready  = (state_q == RUN) && (beats_left_q != '0);
        accept    = in_ready && bus.in_valid;
        // Idle cycles feed zeros so the spm never sees stale operands.
        spm_ops_d = accept ? spm_beat_t'({bus.a0, bus.b0, bus.a1, bus.b1}) : spm_beat_t'('0);

        if (tag_oldest) begin
            acc_d = acc_q + bus.spm_q;
        end

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    acc_d = '0;
                    if (bus.len == '0) begin
                        state_d = DONE;
                    end else begin
                        beats_left_d = bus.len;
                        state_d      = RUN;
                    end
                end
            end
            RUN: begin
                if (accept) begin
                    beats_left_d = beats_left_q - LEN_W'(1);
                    if (beats_left_q == LEN_W'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pipe_empty_next) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            state_q      <= IDLE;
            beats_left_q <= '0;
            acc_q        <= '0;
            spm_ops_q    <= '0;
        end else begin
            state_q      <= state_d;
            beats_left_q <= beats_left_d;
            acc_q        <= acc_d;
            spm_ops_q    <= spm_ops_d;
        end
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.in_ready  = in_ready;
    assign bus.res_valid = (state_q == DONE);
    assign bus.res_data  = acc_q;
    assign bus.spm_a0    = spm_ops_q.a0;
    assign bus.spm_b0    = spm_ops_q.b0;
    assign bus.spm_a1    = spm_ops_q.a1;
    assign bus.spm_b1    = spm_ops_q.b1;

endmodule

// File: tb/tb_spm_seq.sv
// tb_spm_seq: scoreboard bench for spm_seq; a behavioural spm sits beside the DUT
// and job results are predicted as a plain modulo-2^32 sum of pair products.
module tb_spm_seq;

    localparam int L  = spm_pkg::SPM_LAT_DEFAULT;
    localparam int LW = 8;

    typedef struct packed {
        logic [31:0] a0;
        logic [31:0] b0;
        logic [31:0] a1;
        logic [31:0] b1;
    } beat_t;

    logic clk    = 1'b0;
    logic areset = 1'b1;

    spm_seq_if #(.LEN_W(LW)) bus ();

    spm_seq #(
        .SPM_LAT (L),
        .LEN_W   (LW)
    ) dut (
        .clk    (clk),
        .areset (areset),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int          assertCount = 0;
    int          failCount   = 0;
    logic [31:0] expQ[$];
    beat_t       beats[$];
    logic [31:0] lastExp = '0;
    bit          bubblePat[7] = '{1, 0, 0, 1, 1, 0, 1};

    // Behavioural spm: sum of two products, L register stages deep.
    logic [31:0] spmPipe[L] = '{default: '0};

    always @(posedge clk) begin
        spmPipe[0] <= bus.spm_a0 * bus.spm_b0 + bus.spm_a1 * bus.spm_b1;
        for (int k = 1; k < L; k++) spmPipe[k] <= spmPipe[k-1];
    end

    assign bus.spm_q = spmPipe[L-1];

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        assertCount++;
        if (got !== want) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    task automatic checkFlag(input string name, input logic got, input logic want);
        assertCount++;
        if (got !== want) begin
            failCount++;
            $display("[TB] FAIL %s: got %0b, expected %0b", name, got, want);
        end
    endtask

    task automatic checkOperands(input string name, input beat_t got, input beat_t want);
        assertCount++;
        if (got !== want) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    function automatic beat_t spmNow();
        return {bus.spm_a0, bus.spm_b0, bus.spm_a1, bus.spm_b1};
    endfunction

    task automatic checkResetState();
        checkFlag("reset_busy", bus.busy, 1'b0);
        checkFlag("reset_in_ready", bus.in_ready, 1'b0);
        checkFlag("reset_res_valid", bus.res_valid, 1'b0);
        checkOutput("reset_res_data", bus.res_data, 32'd0);
        checkOperands("reset_spm", spmNow(), beat_t'('0));
    endtask

    task automatic addBeat(input logic [31:0] a0, input logic [31:0] b0,
                           input logic [31:0] a1, input logic [31:0] b1);
        beats.push_back({a0, b0, a1, b1});
    endtask

    task automatic addRandomBeats(input int n);
        for (int k = 0; k < n; k++) addBeat($urandom, $urandom, $urandom, $urandom);
    endtask

    // Monitor: every result handshake pops the oldest prediction.
    always @(negedge clk) begin
        if (areset && bus.res_valid && bus.res_ready) begin
            if (expQ.size() == 0) begin
                assertCount++;
                failCount++;
                $display("[TB] FAIL unexpected_result: got %0h, expected no result", bus.res_data);
            end else begin
                checkOutput("result", bus.res_data, expQ.pop_front());
            end
        end
    end

    // Issues one job from the beats queue; returns at the negedge after the last beat edge.
    task automatic applyStimulus(input int n, input int mode, input bit injectStart);
        int          i        = 0;
        int          cyc      = 0;
        bit          v        = 1'b0;
        bit          prevAcc  = 1'b0;
        beat_t       prevBeat = '0;
        logic [31:0] exp      = '0;

        for (int k = 0; k < n; k++) begin
            exp += beats[k].a0 * beats[k].b0 + beats[k].a1 * beats[k].b1;
        end
        expQ.push_back(exp);
        lastExp = exp;

        bus.start = 1'b1;
        bus.len   = LW'(n);
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.len   = '0;

        while (i < n && cyc < 200) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = bubblePat[cyc % 7];
                default: v = 1'($urandom_range(0, 1));
            endcase
            bus.in_valid = v;
            {bus.a0, bus.b0, bus.a1, bus.b1} = beats[i];
            if (injectStart && cyc == 0) begin
                bus.start = 1'b1;
                bus.len   = LW'(9);
            end
            @(negedge clk);
            if (cyc > 0) checkOperands("spm_operands", spmNow(), prevAcc ? prevBeat : beat_t'('0));
            checkFlag("in_ready_run", bus.in_ready, 1'b1);
            prevAcc  = v;
            prevBeat = beats[i];
            @(posedge clk); #1;
            bus.start = 1'b0;
            bus.len   = '0;
            if (v) i++;
            cyc++;
        end
        bus.in_valid = 1'b0;
        if (i < n) begin
            assertCount++;
            failCount++;
            $display("[TB] FAIL stream_timeout: got %0d beats, expected %0d", i, n);
        end
        @(negedge clk);
        checkOperands("spm_operands", spmNow(), prevAcc ? prevBeat : beat_t'('0));
    endtask

    task automatic awaitResult(input int n, input int hold);
        int w = 0;
        if (n > 0) begin
            checkFlag("res_valid_early", bus.res_valid, 1'b0);
            for (int k = 1; k <= L + 1; k++) begin
                @(negedge clk);
                checkFlag("res_valid_latency", bus.res_valid, k == L + 1);
            end
        end else begin
            @(negedge clk);
            checkFlag("res_valid_len0", bus.res_valid, 1'b1);
            checkOutput("res_data_len0", bus.res_data, 32'd0);
            checkOperands("spm_len0", spmNow(), beat_t'('0));
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            checkFlag("hold_res_valid", bus.res_valid, 1'b1);
            checkOutput("hold_res_data", bus.res_data, lastExp);
        end
        if (hold > 0) begin
            @(posedge clk); #1;
            bus.res_ready = 1'b1;
        end
        do begin
            @(negedge clk);
            w++;
        end while (bus.busy && w < 20);
        checkFlag("return_idle", bus.busy, 1'b0);
        @(posedge clk); #1;
        bus.res_ready = 1'b1;
    endtask

    task automatic runJob(input int n, input int mode, input bit injectStart, input int hold);
        bus.res_ready = (hold == 0);
        applyStimulus(n, mode, injectStart);
        awaitResult(n, hold);
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.len       = '0;
        bus.in_valid  = 1'b0;
        bus.a0        = '0;
        bus.b0        = '0;
        bus.a1        = '0;
        bus.b1        = '0;
        bus.res_ready = 1'b1;

        #2 areset = 1'b0;
        #10;
        checkResetState();
        @(negedge clk);
        areset = 1'b1;
        @(posedge clk); #1;

        $display("[TB] single beat");
        beats.delete();
        addBeat(32'd3, 32'd4, 32'd5, 32'd6);
        runJob(1, 0, 1'b0, 0);

        $display("[TB] back-to-back, bubbles, backpressure");
        beats.delete();
        addBeat(32'd1, 32'd1, 32'd1, 32'd1);
        addBeat(32'd2, 32'd2, 32'd2, 32'd2);
        addBeat(32'hFFFF_FFFD, 32'd1, 32'd0, 32'd0);
        addBeat(32'd10, 32'd10, 32'd0, 32'd0);
        runJob(4, 0, 1'b0, 0);
        runJob(4, 1, 1'b0, 0);
        runJob(4, 0, 1'b0, 5);

        $display("[TB] len zero and wrap");
        beats.delete();
        runJob(0, 0, 1'b0, 2);
        beats.delete();
        addBeat(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        runJob(1, 0, 1'b0, 3);

        $display("[TB] ignored start");
        beats.delete();
        addRandomBeats(2);
        runJob(2, 0, 1'b1, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkFlag("no_second_job", bus.busy, 1'b0);
        end
        @(posedge clk); #1;

        $display("[TB] reset mid-job");
        beats.delete();
        addRandomBeats(3);
        bus.res_ready = 1'b1;
        applyStimulus(3, 0, 1'b0);
        @(negedge clk);
        areset = 1'b0;
        #1;
        checkResetState();
        expQ.delete();
        @(negedge clk);
        areset = 1'b1;
        @(posedge clk); #1;
        beats.delete();
        addBeat(32'd1, 32'd1, 32'd1, 32'd1);
        runJob(1, 0, 1'b0, 0);

        $display("[TB] random jobs");
        for (int j = 0; j < 8; j++) begin
            int n;
            n = $urandom_range(1, 12);
            beats.delete();
            addRandomBeats(n);
            runJob(n, $urandom_range(0, 2), 1'b0, $urandom_range(0, 3));
        end

        checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
